// File: rtl/secded_pkg.sv
// ============================================================================
// Module  : secded_pkg
// Purpose : Shared types for the Hamming(16,11) SECDED memory decode engine.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package secded_pkg;

    typedef logic [15:0] codeword_t;
    typedef logic [1:0]  err_flag_t;

    localparam err_flag_t ERR_NONE = 2'b00;
    localparam err_flag_t ERR_SGL  = 2'b01;
    localparam err_flag_t ERR_DBL  = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        DEC   = 3'd3,
        WR_LO = 3'd4,
        WR_HI = 3'd5,
        DONE  = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/secded_dec16.sv
// ============================================================================
// Module  : secded_dec16
// Purpose : Combinational Hamming(16,11) SECDED decode of one codeword.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module secded_dec16
    import secded_pkg::*;
(
    input  codeword_t   i_codeword,
    output logic [10:0] o_data,
    output err_flag_t   o_flag
);

    // Codeword positions of d1..d11; powers of two hold the check bits.
    localparam int c_POS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    logic [3:0] w_syn;
    logic       w_par;

    always_comb begin
        w_syn = '0;
        for (int k = 1; k < 16; k++) begin
            if (i_codeword[k]) begin
                w_syn = w_syn ^ 4'(k);
            end
        end
        w_par = ^i_codeword;
    end

    // Odd parity marks a single error at bit w_syn (syndrome 0 means p0 itself).
    always_comb begin
        o_data = '0;
        for (int j = 0; j < 11; j++) begin
            o_data[j] = i_codeword[c_POS[j]] ^ (w_par && (w_syn == 4'(c_POS[j])));
        end
    end

    always_comb begin
        o_flag = ERR_NONE;
        if (w_par) begin
            o_flag = ERR_SGL;
        end else if (w_syn != 4'd0) begin
            o_flag = ERR_DBL;
        end
    end

endmodule

`default_nettype wire

// File: rtl/secded_mem_decoder.sv
// ============================================================================
// Module  : secded_mem_decoder
// Purpose : Reads NUM_WORDS byte-pair codewords, writes corrected results back.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module secded_mem_decoder
    import secded_pkg::*;
#(
    parameter int NUM_WORDS = 15,
    parameter int IN_BASE   = 30,
    parameter int OUT_BASE  = 0,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data,
    output logic [3:0]    err1_cnt,
    output logic [3:0]    err2_cnt
);

    localparam int              c_IW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(NUM_WORDS - 1);
    localparam logic [AW-1:0]   c_IN   = AW'(IN_BASE);
    localparam logic [AW-1:0]   c_OUT  = AW'(OUT_BASE);

    state_t          r_state;
    logic [c_IW-1:0] r_idx;
    logic [c_IW-1:0] w_idx_nxt;
    logic [7:0]      r_lo;
    logic [7:0]      r_hi;
    logic [7:0]      r_res_hi;
    logic [AW-1:0]   w_off;
    logic [AW-1:0]   w_off_nxt;
    logic [10:0]     w_data;
    err_flag_t       w_flag;
    logic [15:0]     w_result;

    assign w_idx_nxt = r_idx + c_IW'(1);
    assign w_off     = AW'({r_idx, 1'b0});
    assign w_off_nxt = AW'({w_idx_nxt, 1'b0});
    assign w_result  = {w_flag, 3'b000, w_data};

    secded_dec16 u_dec (
        .i_codeword ({r_hi, r_lo}),
        .o_data     (w_data),
        .o_flag     (w_flag)
    );

    // Memory-side outputs are registered, so each is loaded on the edge that
    // enters the state which uses it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_lo        <= '0;
            r_hi        <= '0;
            r_res_hi    <= '0;
            done        <= 1'b0;
            mem_addr    <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
            err1_cnt    <= '0;
            err2_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state   <= RD_LO;
                        r_idx     <= '0;
                        done      <= 1'b0;
                        err1_cnt  <= '0;
                        err2_cnt  <= '0;
                        mem_addr  <= c_IN;
                        mem_wr_en <= 1'b0;
                    end
                end
                RD_LO: begin
                    r_lo     <= mem_rd_data;
                    mem_addr <= c_IN + w_off + AW'(1);
                    r_state  <= RD_HI;
                end
                RD_HI: begin
                    r_hi    <= mem_rd_data;
                    r_state <= DEC;
                end
                DEC: begin
                    r_res_hi    <= w_result[15:8];
                    mem_addr    <= c_OUT + w_off;
                    mem_wr_en   <= 1'b1;
                    mem_wr_data <= w_result[7:0];
                    if (w_flag == ERR_SGL && err1_cnt != 4'hF) begin
                        err1_cnt <= err1_cnt + 4'd1;
                    end
                    if (w_flag == ERR_DBL && err2_cnt != 4'hF) begin
                        err2_cnt <= err2_cnt + 4'd1;
                    end
                    r_state <= WR_LO;
                end
                WR_LO: begin
                    mem_addr    <= c_OUT + w_off + AW'(1);
                    mem_wr_data <= r_res_hi;
                    r_state     <= WR_HI;
                end
                WR_HI: begin
                    mem_wr_en <= 1'b0;
                    if (r_idx == c_LAST) begin
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx    <= w_idx_nxt;
                        mem_addr <= c_IN + w_off_nxt;
                        r_state  <= RD_LO;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    mem_wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_secded_mem_decoder.sv
// ============================================================================
// Module  : tb_secded_mem_decoder
// Purpose : Scoreboard bench for secded_mem_decoder against a codeword-search model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_secded_mem_decoder;

    localparam int NUM_WORDS = 15;
    localparam int IN_BASE   = 30;
    localparam int OUT_BASE  = 0;
    localparam int AW        = 8;
    localparam int POS [11]  = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data;
    logic          mem_wr_en;
    logic [7:0]    mem_wr_data;
    logic [3:0]    err1_cnt;
    logic [3:0]    err2_cnt;

    logic [7:0]  in_mem  [256];
    logic [7:0]  out_mem [256];
    logic [15:0] words   [NUM_WORDS];
    logic [15:0] exp_res [NUM_WORDS];
    logic [15:0] exp_q   [$];
    int          cur_mode;
    int          m_e1;
    int          m_e2;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    secded_mem_decoder #(
        .NUM_WORDS (NUM_WORDS),
        .IN_BASE   (IN_BASE),
        .OUT_BASE  (OUT_BASE),
        .AW        (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .err1_cnt    (err1_cnt),
        .err2_cnt    (err2_cnt)
    );

    assign mem_rd_data = in_mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) out_mem[mem_addr] <= mem_wr_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: place data at the non-power-of-two positions, set each check
    // bit to even parity over its group, then overall parity in bit 0.
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] w;
        logic        b;
        w = '0;
        for (int j = 0; j < 11; j++) w[POS[j]] = d[j];
        for (int p = 1; p < 16; p = p * 2) begin
            b = 1'b0;
            for (int k = 1; k < 16; k++) if ((k & p) != 0 && k != p) b = b ^ w[k];
            w[p] = b;
        end
        w[0] = ^w[15:1];
        return w;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] w);
        logic [10:0] d;
        for (int j = 0; j < 11; j++) d[j] = w[POS[j]];
        return d;
    endfunction

    // Valid codeword -> clean; a codeword one flip away -> corrected; else double.
    function automatic logic [15:0] model(input logic [15:0] w);
        logic [15:0] c;
        if (encode(extract(w)) == w) return {5'b00000, extract(w)};
        for (int j = 0; j < 16; j++) begin
            c = w ^ (16'd1 << j);
            if (encode(extract(c)) == c) return {5'b01000, extract(c)};
        end
        return {5'b10000, extract(w)};
    endfunction

    task automatic prepare(input int mode);
        logic [15:0] dir [4];
        logic [15:0] w;
        int          nflip;
        int          a;
        dir = '{16'h000F, 16'h0007, 16'h000E, 16'h0027};
        cur_mode = mode;
        for (int i = 0; i < NUM_WORDS; i++) begin
            w = encode(11'($urandom));
            if (mode == 1) begin
                w = w ^ (16'd1 << i);
            end else begin
                nflip = $urandom_range(0, 2);
                a     = $urandom_range(0, 15);
                if (nflip >= 1) w = w ^ (16'd1 << a);
                if (nflip == 2) w = w ^ (16'd1 << ((a + $urandom_range(1, 15)) % 16));
            end
            if (mode == 0 && i < 4) w = dir[i];
            words[i] = w;
            in_mem[8'(IN_BASE + 2 * i)]     = w[7:0];
            in_mem[8'(IN_BASE + 2 * i + 1)] = w[15:8];
        end
    endtask

    task automatic push_expected();
        logic [15:0] dexp [4];
        logic [15:0] r;
        dexp = '{16'h0001, 16'h4001, 16'h4001, 16'h8002};
        m_e1 = 0;
        m_e2 = 0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            r = (cur_mode == 0 && i < 4) ? dexp[i] : model(words[i]);
            exp_res[i] = r;
            exp_q.push_back({8'(OUT_BASE + 2 * i), r[7:0]});
            exp_q.push_back({8'(OUT_BASE + 2 * i + 1), r[15:8]});
            if (r[15:11] == 5'b01000 && m_e1 < 15) m_e1++;
            if (r[15:11] == 5'b10000 && m_e2 < 15) m_e2++;
        end
    endtask

    // Counts edges after the accepting edge until done is seen.
    task automatic wait_done(input bit pulse, input string tag);
        int n;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (done) break;
            if (pulse) start = (n < 70) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        chk($sformatf("%s cycles to done", tag), n, 75);
    endtask

    task automatic launch(input bit hold, input bit pulse, input string tag);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        chk($sformatf("%s done drop", tag), done, 0);
        wait_done(pulse, tag);
    endtask

    task automatic check_results(input string tag);
        chk($sformatf("%s err1_cnt", tag), err1_cnt, m_e1);
        chk($sformatf("%s err2_cnt", tag), err2_cnt, m_e2);
        chk($sformatf("%s pending writes", tag), exp_q.size(), 0);
        for (int i = 0; i < NUM_WORDS; i++) begin
            chk($sformatf("%s out word %0d", tag, i),
                {out_mem[8'(OUT_BASE + 2 * i + 1)], out_mem[8'(OUT_BASE + 2 * i)]}, exp_res[i]);
        end
    endtask

    always @(negedge clk) begin
        if (reset && mem_wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected write: addr 0x%0h data 0x%0h, none required", mem_addr, mem_wr_data);
            end else begin
                automatic logic [15:0] e = exp_q.pop_front();
                chk("write addr", mem_addr, e[15:8]);
                chk("write data", mem_wr_data, e[7:0]);
            end
        end
        if (reset && done) chk("wr_en while done", mem_wr_en, 0);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            in_mem[i]  = 8'h00;
            out_mem[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset done", done, 0);
        chk("reset wr_en", mem_wr_en, 0);
        chk("reset addr", mem_addr, 0);
        chk("reset wr_data", mem_wr_data, 0);
        chk("reset err1", err1_cnt, 0);
        chk("reset err2", err2_cnt, 0);
        @(negedge clk);
        reset = 1'b1;

        // Directed clean/single/p0/double words plus random mix.
        prepare(0);
        push_expected();
        launch(1'b0, 1'b0, "T1-3");
        check_results("T1-3");

        // One flip at position i in word i, with start pulses while busy.
        prepare(1);
        push_expected();
        launch(1'b0, 1'b1, "T4");
        check_results("T4");

        // Reset during a write, then a full run on fresh data.
        prepare(2);
        push_expected();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        chk("T5 wr_en before reset", mem_wr_en, 1);
        reset = 1'b0;
        #1;
        chk("T5 done at reset", done, 0);
        chk("T5 wr_en at reset", mem_wr_en, 0);
        chk("T5 addr at reset", mem_addr, 0);
        chk("T5 err1 at reset", err1_cnt, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("T5 idle done", done, 0);
        prepare(2);
        push_expected();
        launch(1'b0, 1'b0, "T5");
        check_results("T5");

        // Start held through DONE restarts; second run with busy pulses.
        prepare(2);
        push_expected();
        launch(1'b1, 1'b0, "T6a");
        check_results("T6a");
        push_expected();
        @(posedge clk);
        #1;
        chk("T6 done fall", done, 0);
        start = 1'b0;
        wait_done(1'b1, "T6b");
        check_results("T6b");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
